uart_transmitter: RTL and testbench

Serial UART transmit engine, the send-side counterpart of the UART receive path. It accepts a parallel byte through a ready/start handshake and shifts it out LSB-first on `tx`. The frame is a start bit, DATA_BITS data bits, an optional parity bit and 1 or 2 stop bits. Bit boundaries are paced by the shared `baud_tick` strobe, one tick per bit period. This is the same tick convention the receiver samples with.

---
 rtl/uart_transmitter.sv | 88 ++++++++
 tb/tb_uart_transmitter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: UART send engine that shifts a byte out LSB-first on tx, paced by baud_tick,
// framed by a start bit, an optional parity bit and 1 or 2 stop bits.
module uart_transmitter #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_ready,
  output logic                 tx_done
);
  typedef enum logic [2:0] {IDLE, ARMED, START, DATA, PAR, STOP} state_t;
  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 parity;
  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_transmitter: unsupported parameter combination");
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      parity   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        if (tx_start) begin
          shift    <= tx_data;
          parity   <= (PARITY == 2) ? ~^tx_data : ^tx_data;
          state    <= ARMED;
          tx_ready <= 1'b0;
        end
      end else if (baud_tick) begin
        case (state)
          ARMED: begin
            tx    <= 1'b0;
            state <= START;
          end
          START: begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            // bit_cnt indexes the data bit currently on the line
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              tx       <= (PARITY != 0) ? parity : 1'b1;
              state    <= (PARITY != 0) ? PAR : STOP;
              stop_cnt <= 1'b0;
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PAR: begin
            tx       <= 1'b1;
            state    <= STOP;
            stop_cnt <= 1'b0;
          end
          STOP: begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: drives four differently configured transmitters and checks each frame
// against a bit-list model built from data, parity and stop-bit rules.
module tb_uart_transmitter;
  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic [3:0] tx_start;
  logic [7:0] tx_data [4];
  wire  [3:0] tx, rdy, done;
  int cfg_db  [4] = '{8, 8, 8, 7};
  int cfg_par [4] = '{0, 1, 2, 0};
  int cfg_sb  [4] = '{1, 1, 1, 2};
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  uart_transmitter #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) d0 (.clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(tx_start[0]), .tx_data(tx_data[0]), .tx(tx[0]), .tx_ready(rdy[0]), .tx_done(done[0]));
  uart_transmitter #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) d1 (.clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(tx_start[1]), .tx_data(tx_data[1]), .tx(tx[1]), .tx_ready(rdy[1]), .tx_done(done[1]));
  uart_transmitter #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) d2 (.clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(tx_start[2]), .tx_data(tx_data[2]), .tx(tx[2]), .tx_ready(rdy[2]), .tx_done(done[2]));
  uart_transmitter #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) d3 (.clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_start(tx_start[3]), .tx_data(tx_data[3][6:0]), .tx(tx[3]), .tx_ready(rdy[3]), .tx_done(done[3]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask
  task automatic tick();
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  endtask
  // Sends one frame on transmitter k; returns the bits a receiver would sample at each tick.
  task automatic run_frame(input int k, input logic [7:0] din, input int gap, input int busy_at,
                           input int long_gap_at, input bit tick_on_accept,
                           output logic [7:0] rx, output logic pbit);
    logic       exp_q[$];
    logic [7:0] d;
    int         db, n, ones;
    bit         held, early_done;
    logic       v;
    db = cfg_db[k];
    d = din & 8'((1 << db) - 1);
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (cfg_par[k] != 0) exp_q.push_back(cfg_par[k] == 1 ? logic'(ones % 2) : logic'(1 - ones % 2));
    for (int i = 0; i < cfg_sb[k]; i++) exp_q.push_back(1'b1);
    n = exp_q.size() + 1;
    rx = 8'h00;
    pbit = 1'bx;
    early_done = 1'b0;
    chk($sformatf("u%0d ready_before_accept", k), rdy[k], 1);
    tx_start[k] = 1'b1;
    tx_data[k] = d;
    baud_tick = tick_on_accept;
    @(negedge clk);
    tx_start[k] = 1'b0;
    baud_tick = 1'b0;
    tx_data[k] = 8'($urandom);
    chk($sformatf("u%0d ready_after_accept", k), rdy[k], 0);
    chk($sformatf("u%0d done_after_accept", k), done[k], 0);
    chk($sformatf("u%0d tx_idle_after_accept", k), tx[k], 1);
    for (int i = 1; i <= n; i++) begin
      repeat (gap - 1) begin
        @(negedge clk);
        if (done[k] !== 1'b0) early_done = 1'b1;
      end
      tick();
      if (i < n) begin
        chk($sformatf("u%0d tick%0d tx", k, i), tx[k], exp_q[i-1]);
        chk($sformatf("u%0d tick%0d ready", k, i), rdy[k], 0);
        if (done[k] !== 1'b0) early_done = 1'b1;
        if (i >= 2 && i < 2 + db) rx[i-2] = tx[k];
        if (cfg_par[k] != 0 && i == db + 2) pbit = tx[k];
        if (i == busy_at) begin
          tx_start[k] = 1'b1;
          tx_data[k] = 8'h3C;
          @(negedge clk);
          tx_start[k] = 1'b0;
          chk($sformatf("u%0d busy_ignored", k), rdy[k], 0);
        end
        if (i == long_gap_at) begin
          v = tx[k];
          held = 1'b1;
          repeat (100) begin
            @(negedge clk);
            if (tx[k] !== v) held = 1'b0;
          end
          chk($sformatf("u%0d gap_hold", k), held, 1);
        end
      end else begin
        chk($sformatf("u%0d end tx", k), tx[k], 1);
        chk($sformatf("u%0d end done", k), done[k], 1);
        chk($sformatf("u%0d end ready", k), rdy[k], 1);
      end
    end
    chk($sformatf("u%0d no_early_done", k), early_done, 0);
  endtask
  task automatic idle_after(input int k);
    @(negedge clk);
    chk($sformatf("u%0d done_one_cycle", k), done[k], 0);
    chk($sformatf("u%0d idle_ready", k), rdy[k], 1);
    chk($sformatf("u%0d idle_tx", k), tx[k], 1);
  endtask
  initial begin
    logic [7:0] rx;
    logic       pb;
    bit         ok;
    int         k;
    reset = 1'b1;
    baud_tick = 1'b0;
    tx_start = '0;
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d reset tx", i), tx[i], 1);
      chk($sformatf("u%0d reset ready", i), rdy[i], 1);
      chk($sformatf("u%0d reset done", i), done[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);
    run_frame(0, 8'hA5, 16, 5, 0, 1'b0, rx, pb);
    chk("default rx_a5", rx, 8'hA5);
    run_frame(0, 8'hC3, 16, 0, 0, 1'b0, rx, pb);
    chk("b2b rx_c3", rx, 8'hC3);
    idle_after(0);
    run_frame(1, 8'hA5, 8, 0, 0, 1'b0, rx, pb);
    chk("even_a5 parity", pb, 0);
    idle_after(1);
    run_frame(2, 8'hA5, 8, 0, 0, 1'b0, rx, pb);
    chk("odd_a5 parity", pb, 1);
    idle_after(2);
    run_frame(1, 8'h07, 8, 0, 0, 1'b0, rx, pb);
    chk("even_07 parity", pb, 1);
    idle_after(1);
    run_frame(3, 8'h55, 10, 0, 0, 1'b0, rx, pb);
    chk("d7s2 rx_55", rx, 8'h55);
    idle_after(3);
    run_frame(0, 8'($urandom), 6, 0, 4, 1'b1, rx, pb);
    idle_after(0);
    // abort a frame with the line low, then make sure it never completes
    tx_start[0] = 1'b1;
    tx_data[0] = 8'h00;
    @(negedge clk);
    tx_start[0] = 1'b0;
    repeat (4) begin
      repeat (3) @(negedge clk);
      tick();
    end
    chk("abort line_low", tx[0], 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort line_high", tx[0], 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("abort tx", tx[0], 1);
    chk("abort ready", rdy[0], 1);
    chk("abort done", done[0], 0);
    ok = 1'b1;
    repeat (14) begin
      repeat (3) @(negedge clk);
      tick();
      if (done[0] !== 1'b0 || tx[0] !== 1'b1) ok = 1'b0;
    end
    chk("abort stays_idle", ok, 1);
    repeat (8) begin
      k = int'($urandom_range(0, 3));
      run_frame(k, 8'($urandom), int'($urandom_range(1, 20)), 0, 0, 1'($urandom), rx, pb);
      idle_after(k);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
